// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Holds the op encodings, the FSM state codes and the two's-complement
// helpers used to form operand magnitudes and to sign-correct results.
package muldiv_pkg;

    // Operation encodings carried on the op input
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;

    // FSM state codes
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    // Widest value the negate helper handles; callers zero-extend into it and
    // truncate the result, which is exact modulo 2^n for any n <= NEG_MAX_W.
    localparam int unsigned NEG_MAX_W = 128;

    function automatic logic is_div_op(logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(logic [1:0] op);
        return ~op[0];
    endfunction

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [NEG_MAX_W-1:0] cond_negate(logic [NEG_MAX_W-1:0] x, logic neg);
        return neg ? (~x + NEG_MAX_W'(1)) : x;
    endfunction

endpackage

// File: rtl/seq_muldiv_unit_if.sv
// Request/result bundle for seq_muldiv_unit.
//   start, op, a, b              : request side (driven by the master)
//   busy, done, hi, lo,
//   div_by_zero                  : status/result side (driven by the unit)
interface seq_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath (purely combinational).
//   i_div     : 1 = restoring-divide step, 0 = shift-add multiply step
//   i_acc     : 2*WIDTH accumulator {upper, lower}
//               multiply: upper = partial product, lower = remaining multiplier bits
//               divide  : upper = partial remainder, lower = dividend/quotient bits
//   i_operand : multiplicand (multiply) or divisor (divide), both as magnitudes
//   o_acc     : accumulator after this iteration
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               i_div,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_div_acc;
    logic               w_unused_diff_msb;

    // Multiply: add multiplicand when the current multiplier bit is set, then
    // shift the whole accumulator right, carry included.
    assign w_mul_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                     + {1'b0, i_operand & {WIDTH{i_acc[0]}}};
    assign w_mul_acc = {w_mul_sum, i_acc[WIDTH-1:1]};

    // Divide: bring in the next dividend bit, trial-subtract the divisor and keep
    // the difference only when it does not go negative.
    assign w_div_shift = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, i_operand});
    assign w_div_diff  = w_div_shift - {1'b0, i_operand};
    // Both candidates are below the divisor, so they fit in WIDTH bits.
    assign w_div_rem   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_acc   = {w_div_rem, i_acc[WIDTH-2:0], w_div_ge};

    assign w_unused_diff_msb = w_div_diff[WIDTH];

    assign o_acc = i_div ? w_div_acc : w_mul_acc;

endmodule

// File: rtl/seq_muldiv_unit.sv
// Multi-cycle signed/unsigned multiply and divide, one bit per cycle.
//   i_clk  : rising-edge clock
//   i_clr  : synchronous active-low reset
//   io_bus : seq_muldiv_unit_if.slave
//            start/op/a/b in; busy/done/hi/lo/div_by_zero out
// MUL/MULU: {hi, lo} = a * b.  DIV/DIVU: lo = quotient, hi = remainder
// (truncating; remainder takes the dividend's sign). Start in cycle 0 gives
// done with valid hi/lo in cycle WIDTH+2; a divide by zero completes in cycle 1.
// WIDTH must be in 4..64.
module seq_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic              i_clk,
    input logic              i_clr,
    seq_muldiv_unit_if.slave io_bus
);
    import muldiv_pkg::*;

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned W2    = 2 * WIDTH;

    logic [1:0]       r_state;
    logic             r_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [W2-1:0]    r_acc;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dbz;

    logic             w_signed;
    logic             w_is_div;
    logic             w_neg_a;
    logic             w_neg_b;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [W2-1:0]    w_acc_next;
    logic [W2-1:0]    w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Operand decode, only meaningful while IDLE
    assign w_signed = is_signed_op(io_bus.op);
    assign w_is_div = is_div_op(io_bus.op);
    assign w_neg_a  = w_signed & io_bus.a[WIDTH-1];
    assign w_neg_b  = w_signed & io_bus.b[WIDTH-1];
    assign w_b_zero = (io_bus.b == '0);

    // |MIN| = 2^(WIDTH-1) is representable as an unsigned WIDTH-bit magnitude.
    assign w_mag_a = WIDTH'(cond_negate(NEG_MAX_W'(io_bus.a), w_neg_a));
    assign w_mag_b = WIDTH'(cond_negate(NEG_MAX_W'(io_bus.b), w_neg_b));

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_div     (r_div),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_acc_next)
    );

    // Sign correction applied in FIX. MIN / -1 wraps naturally to lo = MIN.
    assign w_prod_fix = W2'(cond_negate(NEG_MAX_W'(r_acc), r_neg_res));
    assign w_quo_fix  = WIDTH'(cond_negate(NEG_MAX_W'(r_acc[WIDTH-1:0]), r_neg_res));
    assign w_rem_fix  = WIDTH'(cond_negate(NEG_MAX_W'(r_acc[W2-1:WIDTH]), r_neg_rem));

    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_state   <= IDLE;
            r_div     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (io_bus.start) begin
                        if (w_is_div && w_b_zero) begin
                            // Complete immediately without entering RUN
                            r_done <= 1'b1;
                            r_dbz  <= 1'b1;
                            r_hi   <= io_bus.a;
                            r_lo   <= '1;
                        end else begin
                            r_dbz     <= 1'b0;
                            r_div     <= w_is_div;
                            r_neg_res <= w_neg_a ^ w_neg_b;
                            r_neg_rem <= w_neg_a;
                            // Multiply iterates over b's bits; divide over a's bits.
                            r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                            r_operand <= w_is_div ? w_mag_b : w_mag_a;
                            r_cnt     <= '0;
                            r_state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                    if (r_div) begin
                        r_lo <= w_quo_fix;
                        r_hi <= w_rem_fix;
                    end else begin
                        r_hi <= w_prod_fix[W2-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io_bus.busy        = (r_state != IDLE);
    assign io_bus.done        = r_done;
    assign io_bus.hi          = r_hi;
    assign io_bus.lo          = r_lo;
    assign io_bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Bench for seq_muldiv_unit: a 32-bit and an 8-bit instance share clock and
// reset. An arithmetic reference model predicts every output on every cycle;
// directed vectors additionally pin latency and result values to literals.
module tb_seq_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic clr;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_muldiv_unit_if #(.WIDTH(32)) bus32 ();
    seq_muldiv_unit_if #(.WIDTH(8))  bus8 ();

    seq_muldiv_unit #(.WIDTH(32)) u_dut32 (
        .i_clk  (clk),
        .i_clr  (clr),
        .io_bus (bus32)
    );

    seq_muldiv_unit #(.WIDTH(8)) u_dut8 (
        .i_clk  (clk),
        .i_clr  (clr),
        .io_bus (bus8)
    );

    // Uniform 64-bit views of both instances, index 0 = 32-bit, 1 = 8-bit
    logic        in_start [2];
    logic [1:0]  in_op    [2];
    logic [63:0] in_a     [2];
    logic [63:0] in_b     [2];
    logic        o_busy   [2];
    logic        o_done   [2];
    logic        o_dbz    [2];
    logic [63:0] o_hi     [2];
    logic [63:0] o_lo     [2];

    assign in_start[0] = bus32.start;
    assign in_op[0]    = bus32.op;
    assign in_a[0]     = 64'(bus32.a);
    assign in_b[0]     = 64'(bus32.b);
    assign o_busy[0]   = bus32.busy;
    assign o_done[0]   = bus32.done;
    assign o_dbz[0]    = bus32.div_by_zero;
    assign o_hi[0]     = 64'(bus32.hi);
    assign o_lo[0]     = 64'(bus32.lo);
    assign in_start[1] = bus8.start;
    assign in_op[1]    = bus8.op;
    assign in_a[1]     = 64'(bus8.a);
    assign in_b[1]     = 64'(bus8.b);
    assign o_busy[1]   = bus8.busy;
    assign o_done[1]   = bus8.done;
    assign o_dbz[1]    = bus8.div_by_zero;
    assign o_hi[1]     = 64'(bus8.hi);
    assign o_lo[1]     = 64'(bus8.lo);

    function automatic int wd(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Plain-arithmetic reference for one operation of width w
    task automatic ref_calc(input int w, input logic [1:0] op, input logic [63:0] a,
                            input logic [63:0] b, output logic [63:0] hi,
                            output logic [63:0] lo, output logic dz);
        logic [63:0] mask, ua, ub, p;
        longint      sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = a & mask;
        ub   = b & mask;
        sa   = ua[w-1] ? $signed(ua | ~mask) : $signed(ua);
        sb   = ub[w-1] ? $signed(ub | ~mask) : $signed(ub);
        dz   = 1'b0;
        hi   = '0;
        lo   = '0;
        case (op)
            OP_MUL: begin
                p  = sa * sb;
                hi = (p >> w) & mask;
                lo = p & mask;
            end
            OP_MULU: begin
                p  = ua * ub;
                hi = (p >> w) & mask;
                lo = p & mask;
            end
            default: begin
                if (ub == 64'd0) begin
                    dz = 1'b1;
                    hi = ua;
                    lo = mask;
                end else if (op == OP_DIV) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q & mask;
                    hi = r & mask;
                end else begin
                    lo = (ua / ub) & mask;
                    hi = (ua % ub) & mask;
                end
            end
        endcase
    endtask

    // Cycle-level model: an accepted op finishes WIDTH+2 cycles after its start
    // cycle; requests are only taken while no op is outstanding.
    int          m_cnt  [2];
    logic [63:0] m_hi   [2];
    logic [63:0] m_lo   [2];
    logic [63:0] m_phi  [2];
    logic [63:0] m_plo  [2];
    logic        m_done [2];
    logic        m_dbz  [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [63:0] rh, rl;
            logic        rz;
            ref_calc(wd(d), in_op[d], in_a[d], in_b[d], rh, rl, rz);
            m_done[d] <= 1'b0;
            if (!clr) begin
                m_cnt[d] <= 0;
                m_hi[d]  <= '0;
                m_lo[d]  <= '0;
                m_dbz[d] <= 1'b0;
            end else if (m_cnt[d] == 0) begin
                if (in_start[d]) begin
                    if (rz) begin
                        m_done[d] <= 1'b1;
                        m_dbz[d]  <= 1'b1;
                        m_hi[d]   <= rh;
                        m_lo[d]   <= rl;
                    end else begin
                        m_cnt[d] <= wd(d) + 1;
                        m_phi[d] <= rh;
                        m_plo[d] <= rl;
                        m_dbz[d] <= 1'b0;
                    end
                end
            end else begin
                m_cnt[d] <= m_cnt[d] - 1;
                if (m_cnt[d] == 1) begin
                    m_done[d] <= 1'b1;
                    m_hi[d]   <= m_phi[d];
                    m_lo[d]   <= m_plo[d];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("w%0d_busy", wd(d)), 64'(o_busy[d]), 64'(m_cnt[d] != 0));
                chk($sformatf("w%0d_done", wd(d)), 64'(o_done[d]), 64'(m_done[d]));
                chk($sformatf("w%0d_dbz", wd(d)), 64'(o_dbz[d]), 64'(m_dbz[d]));
                chk($sformatf("w%0d_hi", wd(d)), o_hi[d], m_hi[d]);
                chk($sformatf("w%0d_lo", wd(d)), o_lo[d], m_lo[d]);
            end
        end
    end

    task automatic drive(input int d, input logic st, input logic [1:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (d == 0) begin
            bus32.start = st;
            bus32.op    = op;
            bus32.a     = a[31:0];
            bus32.b     = b[31:0];
        end else begin
            bus8.start = st;
            bus8.op    = op;
            bus8.a     = a[7:0];
            bus8.b     = b[7:0];
        end
    endtask

    task automatic set_start(input int d, input logic st);
        if (d == 0) bus32.start = st;
        else        bus8.start  = st;
    endtask

    // Single-pulse request, then wait (bounded) for done and check literals
    task automatic run_op(input int d, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] ehi, input logic [63:0] elo,
                          input logic edbz, input int elat, input string nm);
        int s;
        bit got;
        got = 1'b0;
        @(negedge clk);
        drive(d, 1'b1, op, a, b);
        s = cyc;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            set_start(d, 1'b0);
            if (o_done[d]) begin
                got = 1'b1;
                chk({nm, "_lat"}, 64'(cyc - s), 64'(elat));
                chk({nm, "_hi"}, o_hi[d], ehi);
                chk({nm, "_lo"}, o_lo[d], elo);
                chk({nm, "_dbz"}, 64'(o_dbz[d]), 64'(edbz));
            end
        end
        chk({nm, "_done_seen"}, 64'(got), 64'd1);
    endtask

    initial begin
        int s, t, nd;
        bit got;
        clr = 1'b0;
        drive(0, 1'b0, OP_MUL, 64'd0, 64'd0);
        drive(1, 1'b0, OP_MUL, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(o_busy[0]), 64'd0);
        chk("rst_done", 64'(o_done[0]), 64'd0);
        chk("rst_hi", o_hi[0], 64'd0);
        chk("rst_lo", o_lo[0], 64'd0);
        chk("rst_dbz", 64'(o_dbz[0]), 64'd0);
        clr = 1'b1;

        run_op(0, OP_MUL, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFFF, 64'hFFFF_FFEB, 1'b0, 34, "mul_7xm3");
        run_op(0, OP_MULU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 64'd1, 1'b0, 34, "mulu_max");
        run_op(0, OP_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 64'd1, 1'b0, 34, "mul_m1xm1");
        run_op(0, OP_MUL, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 64'd0, 1'b0, 34, "mul_min");
        run_op(0, OP_DIV, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFD, 1'b0, 34, "div_m7d2");
        run_op(0, OP_DIV, 64'd7, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFD, 1'b0, 34, "div_7dm2");
        run_op(0, OP_DIVU, 64'd100, 64'd7, 64'd2, 64'd14, 1'b0, 34, "divu_100d7");
        run_op(0, OP_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 64'h8000_0000, 1'b0, 34, "div_ovf");
        run_op(0, OP_DIVU, 64'h64, 64'd0, 64'h64, 64'hFFFF_FFFF, 1'b1, 1, "divu_by0");
        run_op(0, OP_MULU, 64'd3, 64'd4, 64'd0, 64'd12, 1'b0, 34, "mulu_after_dz");

        // start pulsed again mid-operation must be ignored
        @(negedge clk);
        drive(0, 1'b1, OP_MUL, 64'd5, 64'd6);
        s = cyc;
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (9) @(negedge clk);
        drive(0, 1'b1, OP_MULU, 64'd9, 64'd9);
        @(negedge clk);
        set_start(0, 1'b0);
        nd = 0;
        t  = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (o_done[0]) begin
                nd++;
                t = cyc;
            end
        end
        chk("ignore_done_count", 64'(nd), 64'd1);
        chk("ignore_lat", 64'(t - s), 64'd34);
        chk("ignore_lo", o_lo[0], 64'd30);

        // start held through the done cycle launches a second op there
        @(negedge clk);
        drive(0, 1'b1, OP_MULU, 64'd11, 64'd13);
        s   = cyc;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (o_done[0]) begin
                got = 1'b1;
                t   = cyc;
                chk("held_first_lo", o_lo[0], 64'd143);
                drive(0, 1'b1, OP_MULU, 64'd5, 64'd6);
            end
        end
        chk("held_first_lat", 64'(t - s), 64'd34);
        @(negedge clk);
        set_start(0, 1'b0);
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (o_done[0]) begin
                got = 1'b1;
                t   = cyc;
            end
        end
        chk("held_second_seen", 64'(got), 64'd1);
        chk("held_second_lat", 64'(t - s), 64'd68);
        chk("held_second_lo", o_lo[0], 64'd30);

        // reset in cycle 15 of a divide; the 8-bit unit finishes its op first
        @(negedge clk);
        drive(0, 1'b1, OP_DIV, 64'hFFFF_FF9C, 64'd7);
        drive(1, 1'b1, OP_DIVU, 64'd200, 64'd9);
        s = cyc;
        @(negedge clk);
        set_start(0, 1'b0);
        set_start(1, 1'b0);
        repeat (14) @(negedge clk);
        chk("pre_rst_lo8", o_lo[1], 64'h16);
        chk("pre_rst_hi8", o_hi[1], 64'h02);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        chk("mid_rst_cycle", 64'(cyc - s), 64'd16);
        chk("mid_rst_busy", 64'(o_busy[0]), 64'd0);
        chk("mid_rst_done", 64'(o_done[0]), 64'd0);
        chk("mid_rst_hi", o_hi[0], 64'd0);
        chk("mid_rst_lo", o_lo[0], 64'd0);
        chk("mid_rst_lo8", o_lo[1], 64'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_done[0]) nd++;
        end
        chk("mid_rst_no_done", 64'(nd), 64'd0);
        run_op(0, OP_DIVU, 64'd100, 64'd7, 64'd2, 64'd14, 1'b0, 34, "post_rst_divu");

        run_op(1, OP_MUL, 64'h80, 64'h80, 64'h40, 64'h00, 1'b0, 10, "mul8_min");
        run_op(1, OP_DIV, 64'h80, 64'hFF, 64'h00, 64'h80, 1'b0, 10, "div8_ovf");
        run_op(1, OP_DIV, 64'h9C, 64'h00, 64'h9C, 64'hFF, 1'b1, 1, "div8_by0");
        run_op(1, OP_MULU, 64'hFF, 64'hFF, 64'hFE, 64'h01, 1'b0, 10, "mulu8_max");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_muldiv_unit.md
Name: seq_muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit that generalises the datapath's single-cycle MUL/DIV path.
Computes signed or unsigned WIDTH x WIDTH products and quotients/remainders one bit per cycle, with a start/busy/done handshake.
Sits beside the ALU. Operands are taken from Y and the bus. The hi/lo results are written into the HI/LO (or Zhigh/Zlow) registers by the control unit when done is high.

Parameters:
WIDTH, 32, operand/result width (>=4); iteration counter width is clog2(WIDTH)+1 (derived localparam)

Ports:
clk  in  1  rising-edge clock
clr  in  1  synchronous active-low reset
start  in  1  request; sampled only in IDLE
op  in  2  00=MUL signed, 01=MULU, 10=DIV signed, 11=DIVU; captured with start
a  in  WIDTH  multiplicand / dividend
b  in  WIDTH  multiplier / divisor
busy  out  1  operation in progress
done  out  1  one-cycle result-valid pulse
hi  out  WIDTH  product[2W-1:W] / remainder
lo  out  WIDTH  product[W-1:0] / quotient
div_by_zero  out  1  last DIV/DIVU had b==0; held until next accepted start

Behaviour:
- Reset (clr==0 at a clk edge): state=IDLE; busy, done, hi, lo and div_by_zero all 0. Reset applies in every state, including mid-operation; the partial result is discarded.
- FSM states: IDLE, RUN, FIX.
  - IDLE & start: capture op, |a|, |b| (magnitudes for signed ops, raw values for unsigned); record the result sign; clear the counter; go RUN.
  - RUN: one iteration per cycle for exactly WIDTH cycles, then go FIX.
  - FIX: apply sign correction; register hi/lo; assert done for one cycle; go IDLE.
- Timing: start high in cycle 0 → busy high in cycles 1..WIDTH+1 → done high and hi/lo valid in cycle WIDTH+2 (cycle 34 for WIDTH=32).
- hi/lo hold their value until the next completion or reset.
- start outside IDLE (RUN, FIX) is ignored and no request is queued. start in the done cycle is legal (state is IDLE).
- Multiply: shift-add on magnitudes into a 2*WIDTH accumulator. Signed result is negated in 2*WIDTH bits when sign(a)^sign(b).
- Divide: restoring division on magnitudes, quotient→lo, remainder→hi. Signed: quotient negated if signs differ; remainder takes the sign of the dividend (truncating division).
- Divide by zero (DIV/DIVU with b==0) at start: no RUN. In cycle 1: done=1, busy=0, div_by_zero=1, lo=all ones, hi=a (unmodified).
- Signed overflow MIN/-1: magnitude arithmetic wraps, giving lo=MIN, hi=0, with no flag.
- MIN operands: |MIN| is held in WIDTH bits unsigned (2^(W-1)), so it is exact.
- div_by_zero is cleared by the next accepted start.
- done and busy are never high together.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MUL, OP_MULU, OP_DIV, OP_DIVU;
  - FSM state enum: IDLE, RUN, FIX;
  - helper function for two's-complement magnitude/negate.
- One natural sub-module: muldiv_step.
  - Combinational single-iteration datapath.
  - Multiply mode: conditional add + shift.
  - Divide mode: trial subtract + shift + quotient bit.
  - Instantiated once and driven by the FSM registers.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD (-3), start in cycle 0 → busy cycles 1..33; done in cycle 34 with hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_by_zero=0.
2. MULU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Same op as MUL → hi=0, lo=1.
3. DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU a=0x64, b=0 → done in cycle 1, busy never high, div_by_zero=1, lo=0xFFFFFFFF, hi=0x64. A following MULU 3*4 → div_by_zero=0, lo=12.
5. Control timing:
   - start pulsed again in cycle 10 of a MUL → ignored; single done in cycle 34.
   - start held high through the done cycle → second op accepted in cycle 34, done in cycle 68.
6. clr=0 in cycle 15 of a DIV → next cycle: IDLE, busy=0, done=0, hi=lo=0. No done follows; a new start works normally. Repeat with WIDTH=8: MUL 0x80*0x80 → hi=0x40, lo=0x00, done in cycle 10.
